// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default rates and sizing helpers.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_HZ   = 50_000_000;
  localparam int unsigned DEFAULT_BIT_RATE = 9600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the transmitter plus the serial line it drives.
interface uart_tx_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    uart_txd;

  modport master (output tx_data, output tx_valid, input tx_ready, input uart_txd);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output uart_txd);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1, flags the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned   CNT_W = cnt_width(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Next count: hold at zero while restarting, wrap at the bit boundary.
  always_comb begin
    count_next = count + CNT_W'(1);
    if (restart || (count == LAST)) begin
      count_next = '0;
    end
  end

  // bit_done is registered so it is high exactly while count sits at LAST.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      bit_done <= 1'b0;
    end else begin
      count    <= count_next;
      bit_done <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int unsigned BIT_RATE     = DEFAULT_BIT_RATE,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     resetn,
  uart_tx_if.slave bus
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned BIT_CNT_MAX    = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
  localparam int unsigned BIT_W          = cnt_width(BIT_CNT_MAX);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_e             state, state_next;
  logic [PAYLOAD_BITS-1:0] shreg, shreg_next;
  logic [BIT_W-1:0]        bit_idx, bit_idx_next;
  logic                    txd, txd_next;
  logic                    ready, ready_next;
  logic                    bit_done;
  logic                    timer_restart;

  // Timer is held at zero in IDLE so the start bit gets a full period.
  assign timer_restart = (state == ST_IDLE);

  uart_bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .resetn   (resetn),
    .restart  (timer_restart),
    .bit_done (bit_done)
  );

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      txd     <= txd_next;
      ready   <= ready_next;
    end
  end

  // Next state, and registered outputs decoded from the next state.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    txd_next     = 1'b1;
    ready_next   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.tx_valid && ready) begin
          state_next   = ST_START;
          shreg_next   = bus.tx_data;
          bit_idx_next = '0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shreg_next = shreg >> 1;
          if (bit_idx == LAST_DATA) begin
            state_next   = ST_STOP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + BIT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_idx == LAST_STOP) begin
            state_next   = ST_IDLE;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ready_next = (state_next == ST_IDLE);
    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shreg_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  assign bus.tx_ready = ready;
  assign bus.uart_txd = txd;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three configurations, scoreboard of expected bytes.
module tb_uart_tx;

  localparam int CPB_A = 4340;  // 50 MHz / 11520
  localparam int CPB_B = 10;    // 50 MHz / 5 MHz
  localparam int CPB_C = 11;    // 50 MHz / 4.5 MHz, truncated

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  uart_tx_if #(.PAYLOAD_BITS(8)) bus_a ();
  uart_tx_if #(.PAYLOAD_BITS(8)) bus_b ();
  uart_tx_if #(.PAYLOAD_BITS(8)) bus_c ();

  uart_tx #(.CLK_HZ(50_000_000), .BIT_RATE(11_520), .PAYLOAD_BITS(8), .STOP_BITS(1))
    dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  uart_tx #(.CLK_HZ(50_000_000), .BIT_RATE(5_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1))
    dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));
  uart_tx #(.CLK_HZ(50_000_000), .BIT_RATE(4_500_000), .PAYLOAD_BITS(8), .STOP_BITS(2))
    dut_c (.clk(clk), .resetn(resetn), .bus(bus_c));

  logic [2:0] line;
  logic [2:0] rdy;
  assign line = {bus_c.uart_txd, bus_b.uart_txd, bus_a.uart_txd};
  assign rdy  = {bus_c.tx_ready, bus_b.tx_ready, bus_a.tx_ready};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    case (which)
      0:       begin bus_a.tx_valid = v; bus_a.tx_data = d; end
      1:       begin bus_b.tx_valid = v; bus_b.tx_data = d; end
      default: begin bus_c.tx_valid = v; bus_c.tx_data = d; end
    endcase
  endtask

  // Present a byte before an edge, expect it accepted on that edge.
  task automatic send(input int which, input logic [7:0] d, input bit hold);
    @(negedge clk);
    drive(which, 1'b1, d);
    sb_q.push_back(d);
    @(posedge clk);
    #2;
    if (!hold) drive(which, 1'b0, d);
  endtask

  // Called right after the accept edge: checks every cycle of the frame.
  task automatic check_frame(input int which, input int cpb, input int stops, input string tag);
    logic [7:0] exp;
    logic [7:0] got;
    logic       expbit;
    int         waited;
    int         bad;
    int         busy;
    exp = 8'h00;
    got = 8'h00;
    waited = 0;
    busy = 0;
    chk({tag, " scoreboard_has_entry"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    @(negedge clk);
    while (line[which] !== 1'b0 && waited < 4 * cpb) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, " start_latency"}, 32'(waited), 32'd0);
    for (int b = 0; b < 9 + stops; b++) begin
      if (b == 0)      expbit = 1'b0;
      else if (b <= 8) expbit = exp[b-1];
      else             expbit = 1'b1;
      bad = 0;
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (line[which] !== expbit) bad++;
        if (rdy[which] !== 1'b0) busy++;
        if (b >= 1 && b <= 8 && c == cpb / 2) got[b-1] = line[which];
      end
      chk($sformatf("%s bit%0d_bad_cycles", tag, b), 32'(bad), 32'd0);
    end
    chk({tag, " ready_high_in_frame"}, 32'(busy), 32'd0);
    chk({tag, " data"}, 32'(got), 32'(exp));
    @(negedge clk);
    chk({tag, " ready_after_frame"}, 32'(rdy[which]), 32'd1);
    chk({tag, " idle_line"}, 32'(line[which]), 32'd1);
  endtask

  initial begin
    logic [7:0] msg [4];
    logic [7:0] d;
    int bad;
    int cyc;
    msg = '{8'h41, 8'h31, 8'h61, 8'h64};

    resetn = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_line", 32'(line), 32'h7);
    chk("reset_ready", 32'(rdy), 32'h0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_ready", 32'(rdy), 32'h7);
    chk("post_reset_line", 32'(line), 32'h7);

    // Full-rate frame at 11520 baud.
    send(0, 8'h41, 1'b0);
    check_frame(0, CPB_A, 1, "a_41");

    // Two stop bits with truncated divider.
    send(2, 8'h00, 1'b0);
    check_frame(2, CPB_C, 2, "c_00");
    send(2, 8'hA5, 1'b0);
    check_frame(2, CPB_C, 2, "c_A5");

    // Back-to-back with tx_valid held high.
    send(1, 8'h31, 1'b1);
    drive(1, 1'b1, 8'h00);
    sb_q.push_back(8'h00);
    check_frame(1, CPB_B, 1, "b_31");
    @(posedge clk);
    #2 drive(1, 1'b0, 8'h00);
    check_frame(1, CPB_B, 1, "b_00_b2b");

    // Input changes mid-frame must not disturb the frame in flight.
    send(1, 8'h55, 1'b0);
    fork
      begin
        repeat (30) @(posedge clk);
        #2 drive(1, 1'b1, 8'hAA);
        @(posedge clk);
        #2 drive(1, 1'b0, 8'hAA);
      end
    join_none
    check_frame(1, CPB_B, 1, "b_55_ignore");
    bad = 0;
    repeat (4 * CPB_B) begin
      @(negedge clk);
      if (line[1] !== 1'b1) bad++;
    end
    chk("no_extra_frame", 32'(bad), 32'd0);

    // Short string through the serial decoder.
    for (int i = 0; i < 4; i++) begin
      send(1, msg[i], 1'b0);
      check_frame(1, CPB_B, 1, $sformatf("b_msg%0d", i));
    end

    // Reset mid-frame: once in a data bit, once during the start bit.
    for (int k = 0; k < 2; k++) begin
      d   = (k == 0) ? 8'hFF : 8'h00;
      cyc = (k == 0) ? 46 : 4;
      @(negedge clk);
      drive(1, 1'b1, d);
      @(posedge clk);
      #2 drive(1, 1'b0, d);
      repeat (cyc) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk($sformatf("rst%0d_line_now", k), 32'(line[1]), 32'd1);
      chk($sformatf("rst%0d_ready_low", k), 32'(rdy[1]), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 resetn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst%0d_ready_after", k), 32'(rdy), 32'h7);
      bad = 0;
      repeat (3 * CPB_B) begin
        @(negedge clk);
        if (line !== 3'b111 || rdy !== 3'b111) bad++;
      end
      chk($sformatf("rst%0d_stays_idle", k), 32'(bad), 32'd0);
    end

    // Normal operation after the aborted frames.
    send(1, 8'hC3, 1'b0);
    check_frame(1, CPB_B, 1, "b_C3_after_reset");

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
